slice_share_sched: RTL and testbench
====================================

Name: slice_share_sched

Overview:
- Round-robin scheduler that shares one 12-bit gate-level slice datapath (INV/OAI222 slice, 12-bit A/B in, 12-bit C out) between two requesters.
- Each request carries 36-bit A/B operands, which the block feeds to the shared slice as three sequential 12-bit beats.
- It assembles the 36-bit result and returns it with the requester id.
- Sits between the hierarchical slice netlist and the bus-side requesters; replaces three parallel slice instances with one time-multiplexed instance.

Parameters:
- SLICE_W, 12, width of one slice beat (A, B and C width of the shared slice).
- NBEATS, 3, beats per request; operand width = SLICE_W*NBEATS.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  2  per-requester request valid.
- req_ready  output  2  per-requester accept, one-hot or zero.
- req_a0, req_a1  input  SLICE_W*NBEATS each  A operand of requester 0 / 1.
- req_b0, req_b1  input  SLICE_W*NBEATS each  B operand of requester 0 / 1.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result consumer ready.
- rsp_id  output  1  requester that owns rsp_data.
- rsp_data  output  SLICE_W*NBEATS  assembled result.
- slice_en  output  1  high while a beat is driven.
- slice_a  output  SLICE_W  A input of the shared slice.
- slice_b  output  SLICE_W  B input of the shared slice.
- slice_c  input  SLICE_W  C output of the shared slice (combinational return).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low at posedge) forces these values:
  - state=IDLE, beat=0, last_grant=1 (requester 0 wins first).
  - All operand/result regs = 0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, slice_en=0, slice_a=0, slice_b=0, busy=0.
  - Reset mid-operation discards the in-flight request; no response is produced.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - req_ready = grant. Grant goes to the sole valid requester, or to !last_grant if both are valid.
  - req_ready is 0 in RUN/DONE.
  - On req_valid[g] && req_ready[g]: latch req_a_g and req_b_g into op regs, id=g, last_grant=g, beat=0, go to RUN.
- RUN:
  - Drives slice_en=1, slice_a=op_a[beat*SLICE_W +: SLICE_W], slice_b likewise.
  - slice_a/slice_b are combinational from flops only; no input-to-output path.
  - At the clock edge, slice_c is captured into res[beat*SLICE_W +: SLICE_W] and beat increments.
  - At beat==NBEATS-1, go to DONE; beat wraps to 0.
- DONE:
  - rsp_valid=1; rsp_data=res and rsp_id=id held stable until rsp_valid && rsp_ready.
  - After that handshake, go to IDLE.
  - No same-cycle accept of a new request in DONE.
- Outside RUN: slice_en=0, slice_a=0, slice_b=0.
- Latency and throughput:
  - Request accepted at cycle T: beats at T+1..T+NBEATS, rsp_valid first high at T+NBEATS+1.
  - With rsp_ready held high, the minimum spacing between accepts is NBEATS+2 cycles.
- Requests arriving while busy are held by the requester (valid must stay high until ready). A requester dropping valid before ready is legal and leaves no effect.
- Back-pressure: rsp_ready low in DONE stalls indefinitely; operands of waiting requesters are not sampled.
- Arbitration is fair: with both requesters continuously valid, grants alternate 0,1,0,1…

Decomposition:
- Shared package slice_sched_pkg holds:
  - SLICE_W and NBEATS defaults.
  - enum state_t {IDLE, RUN, DONE}.
  - Function beat_sel(vec, idx) returning the SLICE_W-wide part-select.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter. Inputs req[1:0] and last_grant; output grant one-hot; purely combinational.
- The shared slice itself stays an external gate-level instance. The bench wraps it as dut + slice netlist.

Test Plan:
- Reset then single req from 0 with A=0, B=0, rsp_ready=1 → beats at T+1..T+3 with slice_en=1; rsp_valid at T+4, rsp_id=0, rsp_data=36'hFFF_FFF_FFF; busy low at T+5.
- req 1 with A=all ones, B=all ones → rsp_data=36'h000_000_000, rsp_id=1. slice_a sequence across beats is FFF,FFF,FFF.
- req 0 with A=36'h123_456_789, B=0 → slice_a beats 789, 456, 123 in that order. rsp_data matches the golden slice model per 12-bit group.
- Both valid continuously for 4 ops → grant order 0,1,0,1; accepts spaced 5 cycles; req_ready never two-hot.
- rsp_ready held low 7 cycles in DONE → rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout; resumes on the rsp_ready pulse.
- rst_n low during RUN beat 1 → next cycle all outputs at reset values, no rsp_valid. The next request is granted to requester 0 and completes correctly.

Source files
------------

// File: rtl/slice_sched_pkg.sv
// rtl/slice_sched_pkg.sv - shared types, widths and beat selection for the slice scheduler
package slice_sched_pkg;

    localparam int SLICE_W = 12;
    localparam int NBEATS  = 3;
    localparam int OP_W    = SLICE_W * NBEATS;
    localparam int BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [SLICE_W-1:0] beat_sel(input logic [OP_W-1:0] vec,
                                                    input logic [BEAT_W-1:0] idx);
        return vec[int'(idx)*SLICE_W +: SLICE_W];
    endfunction

endpackage

// File: rtl/slice_share_sched_rr_arb2.sv
// rtl/slice_share_sched_rr_arb2.sv - two-way round-robin arbiter, combinational
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On contention the requester that did not win last time gets the grant.
    assign grant[0] = req[0] & (~req[1] | last_grant);
    assign grant[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/slice_share_sched.sv
// rtl/slice_share_sched.sv - time-multiplexes one 12-bit slice between two 36-bit requesters
module slice_share_sched
    import slice_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_a0,
    input  logic [OP_W-1:0]   req_a1,
    input  logic [OP_W-1:0]   req_b0,
    input  logic [OP_W-1:0]   req_b1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [OP_W-1:0]   rsp_data,
    output logic              slice_en,
    output logic [SLICE_W-1:0] slice_a,
    output logic [SLICE_W-1:0] slice_b,
    input  logic [SLICE_W-1:0] slice_c,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [OP_W-1:0]   op_a_q, op_a_d;
    logic [OP_W-1:0]   op_b_q, op_b_d;
    logic [OP_W-1:0]   res_q, res_d;
    logic [1:0]        grant;

    rr_arb2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign req_ready = (state_q == IDLE) ? grant : 2'b00;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        res_d        = res_q;
        case (state_q)
            IDLE: begin
                if (req_valid[0] && req_ready[0]) begin
                    op_a_d       = req_a0;
                    op_b_d       = req_b0;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    beat_d       = '0;
                    state_d      = RUN;
                end else if (req_valid[1] && req_ready[1]) begin
                    op_a_d       = req_a1;
                    op_b_d       = req_b1;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    beat_d       = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                res_d[int'(beat_q)*SLICE_W +: SLICE_W] = slice_c;
                if (beat_q == BEAT_W'(NBEATS-1)) begin
                    beat_d  = '0;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            res_q        <= res_d;
        end
    end

    // Slice drive comes only from flops so the slice sees no path from requester inputs.
    assign slice_en  = (state_q == RUN);
    assign slice_a   = slice_en ? beat_sel(op_a_q, beat_q) : '0;
    assign slice_b   = slice_en ? beat_sel(op_b_q, beat_q) : '0;
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = res_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_slice_share_sched.sv
// tb/tb_slice_share_sched.sv - self-checking bench for slice_share_sched with a behavioural slice
module tb_slice_share_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [35:0] req_a0, req_a1, req_b0, req_b1;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [35:0] rsp_data;
    logic        slice_en;
    logic [11:0] slice_a, slice_b, slice_c;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit two_hot  = 1'b0;

    logic [36:0] sb[$];
    int          grant_log[$];
    int          acc_cyc[$];

    typedef struct {
        int          id;
        logic [35:0] a;
        logic [35:0] b;
        logic [35:0] exp;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the gate-level slice: NOR per bit.
    assign slice_c = ~(slice_a | slice_b);

    slice_share_sched dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .slice_en(slice_en), .slice_a(slice_a), .slice_b(slice_b), .slice_c(slice_c),
        .busy(busy)
    );

    function automatic logic [35:0] model(input logic [35:0] a, input logic [35:0] b);
        return ~(a | b);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready[0] && req_ready[1]) two_hot = 1'b1;
            if (req_valid[0] && req_ready[0]) begin
                sb.push_back({1'b0, model(req_a0, req_b0)});
                grant_log.push_back(0);
                acc_cyc.push_back(cyc);
            end
            if (req_valid[1] && req_ready[1]) begin
                sb.push_back({1'b1, model(req_a1, req_b1)});
                grant_log.push_back(1);
                acc_cyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 1, 0);
                end else begin
                    logic [36:0] e;
                    e = sb.pop_front();
                    check("sb_rsp_id", rsp_id, e[36]);
                    check("sb_rsp_data", rsp_data, e[35:0]);
                end
            end
        end
    end

    task automatic do_accept(input int g, input logic [35:0] a, input logic [35:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        if (g == 0) begin req_a0 = a; req_b0 = b; end
        else begin req_a1 = a; req_b1 = b; end
        req_valid[g] = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[g]) ok = 1'b1;
        end
        check("accept_timeout", ok, 1);
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) ok = 1'b1;
        end
        check("idle_timeout", ok, 1);
    endtask

    initial begin
        logic [11:0] beat_val;
        logic [35:0] hold_data;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        vecs[0] = '{0, 36'h000_000_000, 36'h000_000_000, 36'hFFF_FFF_FFF};
        vecs[1] = '{1, 36'hFFF_FFF_FFF, 36'hFFF_FFF_FFF, 36'h000_000_000};
        vecs[2] = '{0, 36'h123_456_789, 36'h000_000_000, 36'hEDC_BA9_876};
        vecs[3] = '{1, 36'hAAA_555_0F0, 36'h000_0F0_00F, 36'h555_A0A_F00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_slice_en", slice_en, 0);
        check("rst_slice_a", slice_a, 0);
        check("rst_slice_b", slice_b, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Table: latency, beat order and returned data per request.
        for (int v = 0; v < 4; v++) begin
            do_accept(vecs[v].id, vecs[v].a, vecs[v].b);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                beat_val = vecs[v].a[k*12 +: 12];
                check($sformatf("v%0d_slice_en_b%0d", v, k), slice_en, 1);
                check($sformatf("v%0d_slice_a_b%0d", v, k), slice_a, beat_val);
                check($sformatf("v%0d_rsp_valid_early_b%0d", v, k), rsp_valid, 0);
            end
            @(negedge clk);
            check($sformatf("v%0d_rsp_valid", v), rsp_valid, 1);
            check($sformatf("v%0d_rsp_id", v), rsp_id, vecs[v].id);
            check($sformatf("v%0d_rsp_data", v), rsp_data, vecs[v].exp);
            check($sformatf("v%0d_slice_en_done", v), slice_en, 0);
            @(negedge clk);
            check($sformatf("v%0d_busy_after", v), busy, 0);
        end

        // Fairness with both requesters continuously valid.
        grant_log.delete(); acc_cyc.delete(); two_hot = 1'b0;
        @(posedge clk); #1;
        req_a0 = 36'h0F0_0F0_0F0; req_b0 = 36'h00F_00F_00F;
        req_a1 = 36'h321_654_987; req_b1 = 36'h800_000_001;
        req_valid = 2'b11;
        for (int i = 0; i < 60 && grant_log.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1; req_valid = 2'b00;
        check("fair_accept_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("fair_grant_%0d", i), grant_log[i], i % 2);
            for (int i = 0; i < 3; i++) check($sformatf("fair_spacing_%0d", i), acc_cyc[i+1] - acc_cyc[i], 5);
        end
        wait_idle();
        check("fair_two_hot", two_hot, 0);

        // Back-pressure in DONE with a waiting requester.
        rsp_ready = 1'b0;
        do_accept(1, 36'h5A5_A5A_123, 36'h0F0_F0F_000);
        repeat (4) @(negedge clk);
        check("bp_rsp_valid_first", rsp_valid, 1);
        hold_data = model(36'h5A5_A5A_123, 36'h0F0_F0F_000);
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_a0 = 36'h111_222_333; req_b0 = 36'h000_000_444;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", k), rsp_valid, 1);
            check($sformatf("bp_data_%0d", k), rsp_data, hold_data);
            check($sformatf("bp_id_%0d", k), rsp_id, 1);
            check($sformatf("bp_ready_%0d", k), req_ready, 2'b00);
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                if (req_ready[0]) ok = 1'b1;
            end
            check("bp_resume_accept", ok, 1);
            @(posedge clk); #1; req_valid = 2'b00;
        end
        wait_idle();

        // Reset during beat 1 of a requester-0 operation.
        do_accept(0, 36'hABC_DEF_012, 36'h000_000_000);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; req_valid = 2'b11;
        req_a0 = 36'h00F_0F0_F00; req_b0 = 36'h100_010_001;
        sb.delete();
        @(negedge clk);
        check("rr_rsp_valid", rsp_valid, 0);
        check("rr_busy", busy, 0);
        check("rr_slice_en", slice_en, 0);
        check("rr_slice_a", slice_a, 0);
        check("rr_rsp_data", rsp_data, 0);
        check("rr_rsp_id", rsp_id, 0);
        check("rr_first_grant", req_ready, 2'b01);
        @(posedge clk); #1; req_valid = 2'b00;
        wait_idle();
        check("sb_empty_end", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
